// File: rtl/axi_arb_pkg.sv
// Shared types and AXI constants for the refill read arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_e;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_e;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Request captured at grant time and held for the whole transaction.
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    grant_e      side;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; remembers the last winner and favours the other on a tie.
module rr_arb2
  import axi_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_i,
  input  logic   req_d,
  input  logic   upd,
  output logic   any,
  output grant_e gnt
);

  grant_e last_q;

  // Pick a winner: a lone requester always wins, a tie goes to the side not granted last.
  always_comb begin
    any = req_i | req_d;
    gnt = GNT_I;
    if (req_i && req_d) begin
      if (last_q == GNT_I) gnt = GNT_D;
      else                 gnt = GNT_I;
    end else if (req_d) begin
      gnt = GNT_D;
    end
  end

  // Record the winner whenever a grant is actually taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             last_q <= GNT_I;
    else if (upd && any)  last_q <= gnt;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates instruction and data refills onto one AXI read port, one burst at a time.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter logic [3:0] I_ID = 4'd0,
  parameter logic [3:0] D_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction side
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  input  logic [7:0]  i_req_len,
  output logic        i_req_ready,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  output logic        i_rlast,
  output logic        i_rerr,
  input  logic        i_flush,
  // data side
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  input  logic [7:0]  d_req_len,
  output logic        d_req_ready,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_rlast,
  output logic        d_rerr,
  // AXI AR
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI R
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  state_e     state_q, state_d;
  req_t       cur_q, nxt_req;
  logic [8:0] cnt_q;
  logic       drop_q;
  logic       any;
  grant_e     gnt;
  logic       grant_fire;
  logic       beat, fwd, len_err, b_err;

  // A flush in IDLE masks the instruction request for that cycle only.
  rr_arb2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .req_i (i_req_valid && !i_flush),
    .req_d (d_req_valid),
    .upd   (grant_fire),
    .any   (any),
    .gnt   (gnt)
  );

  assign grant_fire = (state_q == S_IDLE) && any && rst;

  // Next-state and handshake outputs; req_ready is gated by rst so nothing is granted in reset.
  always_comb begin
    state_d     = state_q;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_fire) begin
          i_req_ready = (gnt == GNT_I);
          d_req_ready = (gnt == GNT_D);
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_DATA;
      end
      S_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Request to latch at grant time, taken from the winning side.
  always_comb begin
    nxt_req.side = gnt;
    if (gnt == GNT_I) begin
      nxt_req.addr = i_req_addr;
      nxt_req.len  = i_req_len;
      nxt_req.id   = I_ID;
    end else begin
      nxt_req.addr = d_req_addr;
      nxt_req.len  = d_req_len;
      nxt_req.id   = D_ID;
    end
  end

  // Beat qualification: foreign IDs are swallowed, length violations are flagged as errors.
  always_comb begin
    beat    = (state_q == S_DATA) && rvalid && (rid == cur_q.id);
    fwd     = beat && !drop_q;
    len_err = (rlast && (cnt_q != {1'b0, cur_q.len})) || (cnt_q > {1'b0, cur_q.len});
    b_err   = (rresp != 2'b00) || len_err;
  end

  // Latched request, beat counter and flush-drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q  <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else if (grant_fire) begin
      cur_q  <= nxt_req;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      if (beat && (cnt_q != '1)) cnt_q <= cnt_q + 9'd1;
      if ((state_q == S_DATA) && rvalid && rlast)
        drop_q <= 1'b0;
      else if (i_flush && (cur_q.side == GNT_I) && (state_q != S_IDLE))
        drop_q <= 1'b1;
    end
  end

  assign arid    = cur_q.id;
  assign araddr  = cur_q.addr;
  assign arlen   = cur_q.len;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;

  assign i_rdata  = rdata;
  assign d_rdata  = rdata;
  assign i_rvalid = fwd && (cur_q.side == GNT_I);
  assign d_rvalid = fwd && (cur_q.side == GNT_D);
  assign i_rlast  = i_rvalid && rlast;
  assign d_rlast  = d_rvalid && rlast;
  assign i_rerr   = i_rvalid && b_err;
  assign d_rerr   = d_rvalid && b_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for the refill read arbiter.
module tb_axi_rd_arbiter;

  logic        clk, rst;
  logic        i_req_valid, i_req_ready, i_rvalid, i_rlast, i_rerr, i_flush;
  logic [31:0] i_req_addr, i_rdata;
  logic [7:0]  i_req_len;
  logic        d_req_valid, d_req_ready, d_rvalid, d_rlast, d_rerr;
  logic [31:0] d_req_addr, d_rdata;
  logic [7:0]  d_req_len;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;

  int n_tests = 0;
  int n_fail  = 0;

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_len(i_req_len),
    .i_req_ready(i_req_ready), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
    .i_rlast(i_rlast), .i_rerr(i_rerr), .i_flush(i_flush),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_len(d_req_len),
    .d_req_ready(d_req_ready), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .d_rlast(d_rlast), .d_rerr(d_rerr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle and expect it to be granted.
  task automatic req(input logic side_d, input logic [31:0] addr, input logic [7:0] len);
    if (side_d) begin d_req_valid = 1; d_req_addr = addr; d_req_len = len; end
    else        begin i_req_valid = 1; i_req_addr = addr; i_req_len = len; end
    #1;
    chk("req_ready", side_d ? d_req_ready : i_req_ready, 1);
    chk("arvalid_idle", arvalid, 0);
    tick();
    if (side_d) d_req_valid = 0;
    else        i_req_valid = 0;
  endtask

  // Hold off arready for dly cycles, checking the AR channel stays put.
  task automatic ar_phase(input int dly, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len);
    for (int k = 0; k <= dly; k++) begin
      if (k == dly) arready = 1;
      #1;
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, addr);
      chk("arlen", arlen, {24'd0, len});
      chk("arid", arid, {28'd0, id});
      chk("arsize_burst", {arsize, arburst}, 5'b010_01);
      chk("rready_addr", rready, 0);
      tick();
    end
    arready = 0;
  endtask

  // Drive one R beat and check where it lands.
  task automatic beat(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                      input logic last, input logic exp_i, input logic exp_d, input logic exp_err);
    rvalid = 1; rid = id; rdata = data; rresp = resp; rlast = last;
    #1;
    chk("rready", rready, 1);
    chk("i_rvalid", i_rvalid, exp_i);
    chk("d_rvalid", d_rvalid, exp_d);
    if (exp_i) begin
      chk("i_rdata", i_rdata, data);
      chk("i_rlast", i_rlast, last);
      chk("i_rerr", i_rerr, exp_err);
    end
    if (exp_d) begin
      chk("d_rdata", d_rdata, data);
      chk("d_rlast", d_rlast, last);
      chk("d_rerr", d_rerr, exp_err);
    end
    tick();
    rvalid = 0; rlast = 0; rresp = 0; rid = 0;
  endtask

  initial begin
    rst = 0; i_req_valid = 0; i_req_addr = 0; i_req_len = 0; i_flush = 0;
    d_req_valid = 0; d_req_addr = 0; d_req_len = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    repeat (2) tick();

    // reset state, with both requesters already asserting
    i_req_valid = 1; i_req_addr = 32'h1000; i_req_len = 0;
    d_req_valid = 1; d_req_addr = 32'h2000; d_req_len = 0;
    #1;
    chk("rst_i_ready", i_req_ready, 0);
    chk("rst_d_ready", d_req_ready, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_arid", arid, 0);
    chk("rst_rvalid", {i_rvalid, d_rvalid, i_rlast, d_rlast, i_rerr, d_rerr}, 0);

    // first tie after reset goes to D
    rst = 1;
    #1;
    chk("tie1_d", d_req_ready, 1);
    chk("tie1_i", i_req_ready, 0);
    tick();
    d_req_valid = 0;
    ar_phase(0, 4'd1, 32'h2000, 0);
    beat(4'd1, 32'hA5A5_0001, 2'b00, 1, 0, 1, 0);
    // both again: now I wins
    d_req_valid = 1;
    #1;
    chk("tie2_i", i_req_ready, 1);
    chk("tie2_d", d_req_ready, 0);
    tick();
    i_req_valid = 0; d_req_valid = 0;
    ar_phase(0, 4'd0, 32'h1000, 0);
    beat(4'd0, 32'hA5A5_0002, 2'b00, 1, 1, 0, 0);

    // lone D burst, arready delayed 3 cycles
    req(1, 32'h1FC0_0100, 8'd7);
    ar_phase(3, 4'd1, 32'h1FC0_0100, 8'd7);
    for (int k = 0; k < 8; k++) beat(4'd1, 32'hD000_0000 + k, 2'b00, k == 7, 0, 1, 0);
    #1;
    chk("idle_rready", rready, 0);
    chk("idle_arvalid", arvalid, 0);

    // flush in IDLE suppresses the I grant for that cycle only
    i_req_valid = 1; i_req_addr = 32'h3000; i_req_len = 8'd7; i_flush = 1;
    #1;
    chk("flush_idle_i", i_req_ready, 0);
    tick();
    i_flush = 0;
    #1;
    chk("flush_idle_i2", i_req_ready, 1);
    tick();
    i_req_valid = 0;
    ar_phase(0, 4'd0, 32'h3000, 8'd7);
    // flush on beat 3: beats 4-8 are swallowed
    for (int k = 0; k < 8; k++) begin
      if (k == 2) i_flush = 1;
      beat(4'd0, 32'h1100_0000 + k, 2'b00, k == 7, k < 3, 0, 0);
      i_flush = 0;
    end
    req(1, 32'h4000, 0);
    ar_phase(0, 4'd1, 32'h4000, 0);
    beat(4'd1, 32'h4444_0000, 2'b00, 1, 0, 1, 0);

    // error response on beat 2 of 4
    req(1, 32'h5000, 8'd3);
    ar_phase(0, 4'd1, 32'h5000, 8'd3);
    beat(4'd1, 32'h5, 2'b00, 0, 0, 1, 0);
    beat(4'd1, 32'h6, 2'b10, 0, 0, 1, 1);
    beat(4'd1, 32'h7, 2'b00, 0, 0, 1, 0);
    beat(4'd1, 32'h8, 2'b00, 1, 0, 1, 0);
    // early rlast on beat 3 of 4
    req(1, 32'h6000, 8'd3);
    ar_phase(0, 4'd1, 32'h6000, 8'd3);
    beat(4'd1, 32'h9, 2'b00, 0, 0, 1, 0);
    beat(4'd1, 32'hA, 2'b00, 0, 0, 1, 0);
    beat(4'd1, 32'hB, 2'b00, 1, 0, 1, 1);
    #1;
    chk("early_last_idle", rready, 0);
    // overrun: len 0, second beat carries rlast
    req(1, 32'h7000, 0);
    ar_phase(0, 4'd1, 32'h7000, 0);
    beat(4'd1, 32'hC, 2'b00, 0, 0, 1, 0);
    beat(4'd1, 32'hD, 2'b00, 1, 0, 1, 1);

    // foreign rid during an I grant is swallowed and not counted
    req(0, 32'h8000, 8'd1);
    ar_phase(0, 4'd0, 32'h8000, 8'd1);
    beat(4'd0, 32'hE, 2'b00, 0, 1, 0, 0);
    beat(4'd5, 32'hF, 2'b00, 0, 0, 0, 0);
    beat(4'd0, 32'h10, 2'b00, 1, 1, 0, 0);

    // reset during DATA abandons the burst
    req(1, 32'h9000, 8'd3);
    ar_phase(0, 4'd1, 32'h9000, 8'd3);
    beat(4'd1, 32'h11, 2'b00, 0, 0, 1, 0);
    i_req_valid = 1; d_req_valid = 1; d_req_addr = 32'hA000; d_req_len = 0;
    rst = 0;
    #1;
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_ready", {i_req_ready, d_req_ready}, 0);
    repeat (2) tick();
    i_req_valid = 0;
    rst = 1;
    #1;
    chk("post_rst_d", d_req_ready, 1);
    tick();
    d_req_valid = 0;
    ar_phase(0, 4'd1, 32'hA000, 0);
    beat(4'd1, 32'h12, 2'b00, 1, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
